// File: rtl/fp_div_arbiter.sv
// rtl/fp_div_arbiter.sv - round-robin arbiter and sequencer sharing one multicycle FP divider
// One transaction in flight at a time; a watchdog turns a hung division into a qNaN error response.
module fp_div_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int Data_size = 32,
    parameter int ID_W      = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*Data_size-1:0] req_a,
    input  logic [NUM_REQ*Data_size-1:0] req_b,
    input  logic [2*NUM_REQ-1:0]         req_round_mode,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [Data_size-1:0]         rsp_data,
    output logic                         rsp_err,
    output logic                         div_start,
    output logic [Data_size-1:0]         div_a,
    output logic [Data_size-1:0]         div_b,
    output logic [1:0]                   div_round_mode,
    input  logic [Data_size-1:0]         div_result,
    input  logic                         div_done,
    output logic                         busy,
    output logic [ID_W-1:0]              grant_id
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [7:0]           TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [ID_W-1:0]      LAST_ID     = ID_W'(NUM_REQ - 1);
    localparam logic [Data_size-1:0] QNAN        = Data_size'(32'h7FC00000);

    state_t                state_q, state_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]       grant_q, grant_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [Data_size-1:0]  div_a_q, div_a_d;
    logic [Data_size-1:0]  div_b_q, div_b_d;
    logic [1:0]            rm_q, rm_d;
    logic [Data_size-1:0]  rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  found;
    logic [ID_W-1:0]       win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            cnt_q      <= '0;
            div_a_q    <= '0;
            div_b_q    <= '0;
            rm_q       <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            div_a_q    <= div_a_d;
            div_b_q    <= div_b_d;
            rm_q       <= rm_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        int idx;
        idx        = 0;
        found      = 1'b0;
        win        = '0;
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        div_a_d    = div_a_q;
        div_b_d    = div_b_q;
        rm_d       = rm_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        req_ready  = '0;
        rsp_valid  = '0;
        div_start  = 1'b0;

        // First pending requester at or above the pointer, wrapping around.
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    req_ready[win] = 1'b1;
                    div_a_d        = req_a[int'(win)*Data_size +: Data_size];
                    div_b_d        = req_b[int'(win)*Data_size +: Data_size];
                    rm_d           = req_round_mode[2*int'(win) +: 2];
                    grant_d        = win;
                    rr_ptr_d       = (win == LAST_ID) ? '0 : win + ID_W'(1);
                    state_d        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                div_start = 1'b1;
                cnt_d     = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (div_done) begin
                    rsp_data_d = div_result;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RESP;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    rsp_data_d = QNAN;
                    rsp_err_d  = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                rsp_valid[grant_q] = 1'b1;
                state_d            = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy           = (state_q != S_IDLE);
    assign grant_id       = grant_q;
    assign div_a          = div_a_q;
    assign div_b          = div_b_q;
    assign div_round_mode = rm_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_err        = rsp_err_q;

endmodule

// File: doc/fp_div_arbiter.md
# fp_div_arbiter

Round-robin arbiter and sequencer that shares one multicycle floating-point divider (start/done handshake, held operands) among `NUM_REQ` requesters. It sits between the scoring/normalisation engines of the face-verify pipeline and the single divider instance. It accepts one request at a time, issues a one-cycle start to the divider and waits for done. It returns the quotient to the originating requester, and a watchdog aborts a hung division.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `Data_size`, 32: operand/result width.
- `ID_W`, 2: width of requester index; must equal ceil(log2(`NUM_REQ`)).
- `TIMEOUT`, 255: cycles in WAIT before abort (1..255, 8-bit counter).

- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  `NUM_REQ`  request pending, one bit per requester.
- `req_a`  in  `NUM_REQ*Data_size`  dividends; requester i at bits [i*Data_size +: Data_size].
- `req_b`  in  `NUM_REQ*Data_size`  divisors, same packing.
- `req_round_mode`  in  `2*NUM_REQ`  rounding mode per requester, [2i +: 2].
- `req_ready`  out  `NUM_REQ`  one-hot accept strobe.
- `rsp_valid`  out  `NUM_REQ`  one-hot, one-cycle result strobe.
- `rsp_data`  out  `Data_size`  quotient, shared by all requesters.
- `rsp_err`  out  1  timeout flag, qualified by `rsp_valid`.
- `div_start`  out  1  one-cycle start to the divider.
- `div_a`, `div_b`  out  `Data_size`  registered divider operands.
- `div_round_mode`  out  2  registered rounding mode.
- `div_result`  in  `Data_size`  divider quotient.
- `div_done`  in  1  divider one-cycle completion pulse.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `grant_id`  out  `ID_W`  index of the request in flight.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any `req_valid` bit is set, pick the winner. The winner is the first set bit searching upward from `rr_ptr`, wrapping modulo `NUM_REQ`.
  - Assert `req_ready[winner]` combinationally in this cycle.
  - Register the winner's operands into `div_a`, `div_b` and `div_round_mode`, and register `grant_id`.
  - Set `rr_ptr` to (winner+1) mod `NUM_REQ`, then go to ISSUE.
  - With no requests, stay in IDLE; `req_ready` is 0.
- ISSUE: `div_start`=1 for exactly this cycle; clear the watchdog counter; go to WAIT.
- WAIT:
  - On `div_done`, capture `div_result` into `rsp_data`, set `rsp_err`=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`, load `rsp_data`=32'h7FC00000, set `rsp_err`=1, go to RESP.
- RESP: `rsp_valid[grant_id]`=1 for one cycle; go to IDLE.
- Requesters hold `req_valid` and operands stable until `req_ready`. Operands are sampled only in the accept cycle, so later changes have no effect.
- `div_done` outside WAIT is ignored.
- Special-case results (NaN, Inf, zero) come from the divider and pass through unmodified.
- Reset values: state IDLE, `rr_ptr` 0, `req_ready` 0, `rsp_valid` 0, `rsp_data` 0, `rsp_err` 0, `div_start` 0, `div_a` 0, `div_b` 0, `div_round_mode` 0, `grant_id` 0, `busy` 0, counter 0.
- Reset mid-operation aborts the transaction and produces no response. The divider must be reset by the same reset event.

## Timing
- Accept at cycle T; `div_start` high at T+1.
- If `div_done` arrives at T+1+L, `rsp_valid` is high at T+2+L.
- The next accept is no earlier than T+3+L. One transaction is in flight at a time, so the divider is never started while busy.
- Timeout: `rsp_valid` is high at T+3+`TIMEOUT` when `div_done` never arrives.
- `rsp_data` and `rsp_err` hold their values until the next RESP.
- `req_ready` and `rsp_valid` are never high in the same cycle.
- Fairness: with all requesters continuously valid, grants go 0,1,2,3,0,… Any requester waits at most `NUM_REQ`-1 transactions.

## Test plan
- Single request: requester 2 sends A=0x40C00000, B=0x40000000 → `req_ready`=4'b0100 in the accept cycle, one `div_start` pulse, `rsp_valid`=4'b0100, `rsp_data`=0x40400000, `rsp_err`=0.
- All four requesters valid from reset, each with 0x3F800000/0x40800000 → grant order 0,1,2,3. Each gets `rsp_data`=0x3E800000, and only one `div_start` occurs per transaction.
- Requester 1 sends 0x3F800000/0x00000000 → `rsp_data`=0x7F800000 delivered to requester 1 only.
- Divider model holds `div_done` low, `TIMEOUT`=16 → `rsp_valid` at T+19 with `rsp_data`=0x7FC00000 and `rsp_err`=1. The next request then completes normally.
- `rst_n` pulsed low during WAIT → all outputs return to reset values immediately and no `rsp_valid` appears. A spurious `div_done` while in IDLE produces no response.
- Requester 0 changes `req_a` the cycle after accept → `rsp_data` reflects the operand sampled in the accept cycle.
